usr_seq_param: RTL and testbench
================================

Name: usr_seq_param

Overview:
Parametrised universal shift register, successor to the fixed 4-bit USR. Adds:
- configurable WIDTH;
- rotate and arithmetic-shift modes;
- a multi-step sequencer that performs N shifts per start/done handshake.

It sits in the datapath library as a general serial/parallel conversion and shifting element. It is also used in single-step mode as a drop-in for the classic USR.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, width of shift-amount input and internal step counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- mode  in  3  operation select (encoding below)
- en  in  1  single-step enable, honoured only when idle and start=0
- start  in  1  request multi-step sequence, honoured only when ready=1
- amount  in  CNT_W  number of steps for a sequence
- pdi  in  WIDTH  parallel data in
- sldi  in  1  serial data in for shift-left (enters bit 0)
- srdi  in  1  serial data in for shift-right (enters bit WIDTH-1)
- pdo  out  WIDTH  register contents
- sldo  out  1  pdo[WIDTH-1] (combinational from register)
- srdo  out  1  pdo[0] (combinational from register)
- ready  out  1  high in IDLE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: pdo=0, state=IDLE, cnt=0, latched mode=000. Outputs under reset: ready=1, busy=0, done=0. A reset asserted in any state takes effect immediately, with no completion or done pulse.
- Mode encoding, one step:
  - 000 hold
  - 001 shift right: {srdi, pdo[W-1:1]}
  - 010 shift left: {pdo[W-2:0], sldi}
  - 011 parallel load pdi
  - 100 rotate right
  - 101 rotate left
  - 110 arithmetic shift right (MSB replicated)
  - 111 reserved, behaves as hold
- Serial inputs are sampled on the edge that performs the step.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1, amount>0, mode!=011: latch mode into mode_q and amount into cnt; go to RUN. No shift on the accepting edge.
  - start=1, mode=011: load pdi on that edge; go to DONE. amount is ignored.
  - start=1, amount=0, mode!=011: go to DONE; pdo unchanged.
  - start=0, en=1: perform one step of the current mode on the edge; stay in IDLE.
  - start=0, en=0: hold.
  - start has priority over en.
- RUN:
  - Each edge performs one step of mode_q and decrements cnt.
  - When cnt==1 on an edge, that is the last step; go to DONE.
  - mode, amount, start and en are ignored. pdi is unused.
- DONE: done=1 for exactly one cycle; pdo held; next edge returns to IDLE. start in DONE is ignored; ready=0.
- Latency: start accepted at edge t with amount N>0 gives steps on edges t+1..t+N, busy high for N cycles, done high in the cycle after edge t+N, ready again one cycle after that.
- amount is not clamped. Values >= WIDTH execute exactly amount steps; rotate wraps naturally, shifts fill completely.
- sldo/srdo update every step, so a sequence streams bits out serially.

Decomposition:
- Package usr_pkg: mode encoding localparams (MODE_HOLD..MODE_ASR) and FSM state encoding (S_IDLE, S_RUN, S_DONE).
- One sub-module, usr_step: purely combinational next-value function (mode, cur, sldi, srdi, pdi -> nxt), parametrised by WIDTH.
- Top holds the register, FSM and counter, and instantiates usr_step once, with the mux selecting the live mode in IDLE and mode_q in RUN.

Test Plan:
All scenarios use WIDTH=8.
1. Reset: rst=1 mid-clock → pdo=00, ready=1, busy=0, done=0 without waiting for an edge. Release, hold 3 cycles → pdo stays 00.
2. Single-step: en=1, mode=011, pdi=96 → pdo=96 after one edge. Then mode=001, srdi=1 → pdo=CB, srdo=1. Then mode=010, sldi=0 → pdo=96.
3. Rotate sequence: pdo=96, start=1, mode=101, amount=3 → busy high 3 cycles, pdo goes 2D, 5A, B4, then done pulses once with pdo=B4, then ready=1.
4. ASR sequence and guard: pdo=96, start, mode=110, amount=2 → pdo=E5, done one cycle. A start with mode=001 issued while busy is ignored, so pdo stays E5 and there is no extra done.
5. amount=0 with mode=001 → DONE on the next edge, pdo unchanged, done pulses once. start with mode=011, pdi=3C → pdo=3C, done next cycle.
6. Reset mid-run: amount=5, shift left, assert rst after 2 steps → pdo=00, state IDLE immediately, no done pulse.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: mode and FSM state encodings shared by the universal shift register blocks
package usr_pkg;
   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SR   = 3'b001;
   localparam logic [2:0] MODE_SL   = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_ROL  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/usr_step.sv
// usr_step: one-step next value; mode/cur/sldi/srdi/pdi in, nxt out (reserved mode holds)
module usr_step
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] cur,
   input  logic             sldi,
   input  logic             srdi,
   input  logic [WIDTH-1:0] pdi,
   output logic [WIDTH-1:0] nxt
);
   assign nxt = mode == MODE_SR   ? {srdi, cur[WIDTH-1:1]} :
                mode == MODE_SL   ? {cur[WIDTH-2:0], sldi} :
                mode == MODE_LOAD ? pdi :
                mode == MODE_ROR  ? {cur[0], cur[WIDTH-1:1]} :
                mode == MODE_ROL  ? {cur[WIDTH-2:0], cur[WIDTH-1]} :
                mode == MODE_ASR  ? {cur[WIDTH-1], cur[WIDTH-1:1]} :
                                    cur;
endmodule

// File: rtl/usr_seq_param.sv
// usr_seq_param: universal shift register with single-step and counted multi-step sequencing;
// in: clk, rst, mode, en, start, amount, pdi, sldi, srdi; out: pdo, sldo, srdo, ready, busy, done
module usr_seq_param
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       mode,
   input  logic             en,
   input  logic             start,
   input  logic [CNT_W-1:0] amount,
   input  logic [WIDTH-1:0] pdi,
   input  logic             sldi,
   input  logic             srdi,
   output logic [WIDTH-1:0] pdo,
   output logic             sldo,
   output logic             srdo,
   output logic             ready,
   output logic             busy,
   output logic             done
);
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       mode_q;
   logic [WIDTH-1:0] nxt;
   // a running sequence keeps the mode captured at start, not the live input
   usr_step #(.WIDTH(WIDTH)) u_step (
      .mode (state == S_RUN ? mode_q : mode),
      .cur  (pdo),
      .sldi (sldi),
      .srdi (srdi),
      .pdi  (pdi),
      .nxt  (nxt)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pdo    <= '0;
         state  <= S_IDLE;
         cnt    <= '0;
         mode_q <= MODE_HOLD;
      end else if (state == S_IDLE) begin
         if (start) begin
            if (mode == MODE_LOAD) begin
               pdo   <= pdi;
               state <= S_DONE;
            end else if (amount == '0) begin
               state <= S_DONE;
            end else begin
               mode_q <= mode;
               cnt    <= amount;
               state  <= S_RUN;
            end
         end else if (en) begin
            pdo <= nxt;
         end
      end else if (state == S_RUN) begin
         pdo <= nxt;
         cnt <= cnt - 1'b1;
         if (cnt == CNT_W'(1)) state <= S_DONE;
      end else begin
         state <= S_IDLE;
      end
   end
   assign sldo  = pdo[WIDTH-1];
   assign srdo  = pdo[0];
   assign ready = state == S_IDLE;
   assign busy  = state == S_RUN;
   assign done  = state == S_DONE;
endmodule

// File: tb/tb_usr_seq_param.sv
// tb_usr_seq_param: scoreboard bench for usr_seq_param with directed vectors at WIDTH=8
module tb_usr_seq_param;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] mode = '0;
   logic       en = 1'b0;
   logic       start = 1'b0;
   logic [3:0] amount = '0;
   logic [7:0] pdi = '0;
   logic       sldi = 1'b0;
   logic       srdi = 1'b0;
   logic [7:0] pdo;
   logic       sldo, srdo, ready, busy, done;
   typedef struct packed {
      logic [7:0] pdo;
      logic       r;
      logic       b;
      logic       d;
   } exp_t;
   exp_t  q[$];
   string nq[$];
   int    vectors = 0;
   int    miscompares = 0;
   usr_seq_param #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .mode(mode), .en(en), .start(start), .amount(amount),
      .pdi(pdi), .sldi(sldi), .srdi(srdi), .pdo(pdo), .sldo(sldo), .srdo(srdo),
      .ready(ready), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   // monitor: one expected observation per falling edge when one is pending
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            exp_t  e;
            string n;
            logic [12:0] got, want;
            e = q.pop_front();
            n = nq.pop_front();
            got  = {pdo, sldo, srdo, ready, busy, done};
            want = {e.pdo, e.pdo[7], e.pdo[0], e.r, e.b, e.d};
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("FAIL %s: got pdo=%h sldo/srdo=%b%b r/b/d=%b%b%b, want pdo=%h sldo/srdo=%b%b r/b/d=%b%b%b",
                        n, pdo, sldo, srdo, ready, busy, done, e.pdo, e.pdo[7], e.pdo[0], e.r, e.b, e.d);
            end
         end
      end
   end
   task automatic expect_(input string n, input logic [7:0] p, input logic r, b, d);
      q.push_back('{pdo: p, r: r, b: b, d: d});
      nq.push_back(n);
   endtask
   // called at negedge+1: drive inputs for the next rising edge, push its outcome
   task automatic cyc(input string n, input logic [2:0] m, input logic e, s, input logic [3:0] a,
                      input logic [7:0] d, input logic sl, sr,
                      input logic [7:0] ep, input logic er, eb, ed);
      mode = m; en = e; start = s; amount = a; pdi = d; sldi = sl; srdi = sr;
      expect_(n, ep, er, eb, ed);
      @(negedge clk);
      #1;
   endtask
   initial begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      expect_("rst_async", 8'h00, 1, 0, 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc("rst_hold", 3'd0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
      cyc("step_load",  3'd3, 1, 0, 0, 8'h96, 0, 0, 8'h96, 1, 0, 0);
      cyc("step_sr",    3'd1, 1, 0, 0, 8'h00, 0, 1, 8'hCB, 1, 0, 0);
      cyc("step_sl",    3'd2, 1, 0, 0, 8'h00, 0, 0, 8'h96, 1, 0, 0);
      cyc("rol_accept", 3'd5, 0, 1, 3, 8'h00, 0, 0, 8'h96, 0, 1, 0);
      cyc("rol_1",      3'd0, 0, 0, 0, 8'h00, 0, 0, 8'h2D, 0, 1, 0);
      cyc("rol_2",      3'd0, 0, 0, 0, 8'h00, 0, 0, 8'h5A, 0, 1, 0);
      cyc("rol_done",   3'd0, 0, 0, 0, 8'h00, 0, 0, 8'hB4, 0, 0, 1);
      cyc("rol_ready",  3'd0, 0, 0, 0, 8'h00, 0, 0, 8'hB4, 1, 0, 0);
      cyc("asr_load",   3'd3, 1, 0, 0, 8'h96, 0, 0, 8'h96, 1, 0, 0);
      cyc("asr_accept", 3'd6, 0, 1, 2, 8'h00, 0, 0, 8'h96, 0, 1, 0);
      cyc("asr_guard1", 3'd1, 1, 1, 3, 8'hFF, 1, 1, 8'hCB, 0, 1, 0);
      cyc("asr_done",   3'd1, 1, 1, 3, 8'hFF, 1, 1, 8'hE5, 0, 0, 1);
      cyc("asr_guard2", 3'd1, 0, 1, 3, 8'hFF, 1, 1, 8'hE5, 1, 0, 0);
      cyc("asr_nodone", 3'd0, 0, 0, 0, 8'h00, 0, 0, 8'hE5, 1, 0, 0);
      cyc("amt0_done",  3'd1, 0, 1, 0, 8'h00, 0, 1, 8'hE5, 0, 0, 1);
      cyc("amt0_ready", 3'd0, 0, 0, 0, 8'h00, 0, 0, 8'hE5, 1, 0, 0);
      cyc("ld_done",    3'd3, 0, 1, 5, 8'h3C, 0, 0, 8'h3C, 0, 0, 1);
      cyc("ld_ready",   3'd0, 0, 0, 0, 8'h00, 0, 0, 8'h3C, 1, 0, 0);
      cyc("sl_accept",  3'd2, 0, 1, 5, 8'h00, 1, 0, 8'h3C, 0, 1, 0);
      cyc("sl_1",       3'd0, 0, 0, 0, 8'h00, 1, 0, 8'h79, 0, 1, 0);
      cyc("sl_2",       3'd0, 0, 0, 0, 8'h00, 1, 0, 8'hF3, 0, 1, 0);
      rst = 1'b1;
      expect_("rst_midrun", 8'h00, 1, 0, 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      cyc("post_rst1",  3'd0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0);
      cyc("post_rst2",  3'd0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
